// File: rtl/diag_psum_collector_if.sv
// Handshake bundle between the diagonal PE array, the psum collector and its downstream consumer.
interface diag_psum_collector_if #(
    parameter int unsigned DW        = 16,
    parameter int unsigned Dimension = 16
);
    localparam int unsigned LW = $clog2(Dimension);

    logic                      diag_valid;
    logic [DW*Dimension-1:0]   diag_in;
    logic                      diag_last;
    logic                      out_ready;
    logic                      out_valid;
    logic [DW-1:0]             out_data;
    logic [LW-1:0]             out_lane;
    logic                      out_last;
    logic                      busy;
    logic                      ovf_err;
    logic                      drop_err;

    modport master (
        output diag_valid, diag_in, diag_last, out_ready,
        input  out_valid, out_data, out_lane, out_last, busy, ovf_err, drop_err
    );

    modport slave (
        input  diag_valid, diag_in, diag_last, out_ready,
        output out_valid, out_data, out_lane, out_last, busy, ovf_err, drop_err
    );
endinterface

// File: rtl/diag_psum_collector.sv
// Accumulates diagonal psum vectors per lane, then drains one reduced lane per beat.
// Optional macro PSUM_SAT_EN: saturating reduction instead of truncation.
module diag_psum_collector #(
    parameter int unsigned DW        = 16,
    parameter int unsigned Dimension = 16,
    parameter int unsigned ACC_W     = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    diag_psum_collector_if.slave  bus
);
    localparam int unsigned LW = $clog2(Dimension);
    localparam logic [LW-1:0] LAST_LANE = LW'(Dimension - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

`ifdef PSUM_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

    logic [1:0]              state, state_nxt;
    logic [LW-1:0]           cnt, cnt_nxt;
    logic signed [ACC_W-1:0] acc      [Dimension];
    logic signed [ACC_W-1:0] acc_nxt  [Dimension];
    logic signed [ACC_W-1:0] lane_ext [Dimension];
    logic signed [ACC_W-1:0] lane_sum [Dimension];
    logic [Dimension-1:0]    lane_ovf;
    logic                    ovf_q, ovf_nxt;
    logic                    drop_q, drop_nxt;
    logic signed [ACC_W-1:0] sel_acc;
    logic [DW-1:0]           red;

    logic                    out_valid_q;
    logic [DW-1:0]           out_data_q;
    logic [LW-1:0]           out_lane_q;
    logic                    out_last_q;
    logic                    busy_q;

    // Per-lane sign extension, wrapping add and signed-overflow detect
    for (genvar k = 0; k < Dimension; k++) begin : g_lane
        assign lane_ext[k] = {{(ACC_W-DW){bus.diag_in[DW*k+DW-1]}}, bus.diag_in[DW*k +: DW]};
        assign lane_sum[k] = acc[k] + lane_ext[k];
        assign lane_ovf[k] = (acc[k][ACC_W-1] == lane_ext[k][ACC_W-1]) &&
                             (lane_sum[k][ACC_W-1] != acc[k][ACC_W-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            drop_q <= 1'b0;
            for (int k = 0; k < Dimension; k++) acc[k] <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ovf_q  <= ovf_nxt;
            drop_q <= drop_nxt;
            for (int k = 0; k < Dimension; k++) acc[k] <= acc_nxt[k];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_q;
        drop_nxt  = drop_q;
        for (int k = 0; k < Dimension; k++) acc_nxt[k] = acc[k];

        case (state)
            IDLE, ACCUM: begin
                if (bus.diag_valid) begin
                    for (int k = 0; k < Dimension; k++) acc_nxt[k] = lane_sum[k];
                    ovf_nxt   = ovf_q | (|lane_ovf);
                    cnt_nxt   = '0;
                    state_nxt = bus.diag_last ? DRAIN : ACCUM;
                end
            end
            DRAIN: begin
                if (bus.diag_valid) drop_nxt = 1'b1;
                if (bus.out_ready) begin
                    if (cnt == LAST_LANE) begin
                        for (int k = 0; k < Dimension; k++) acc_nxt[k] = '0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + LW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Reduction of the lane that will be presented after this edge
    always_comb begin
        sel_acc = acc_nxt[cnt_nxt];
`ifdef PSUM_SAT_EN
        if (sel_acc > SAT_MAX)      red = DW'(SAT_MAX);
        else if (sel_acc < SAT_MIN) red = DW'(SAT_MIN);
        else                        red = DW'(sel_acc);
`else
        red = DW'(sel_acc);
`endif
    end

    // Outputs are registered from next-state values so the first beat appears one cycle after diag_last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else if (state_nxt == DRAIN) begin
            out_valid_q <= 1'b1;
            out_data_q  <= red;
            out_lane_q  <= cnt_nxt;
            out_last_q  <= (cnt_nxt == LAST_LANE);
            busy_q      <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_lane  = out_lane_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.ovf_err   = ovf_q;
    assign bus.drop_err  = drop_q;
endmodule

// File: doc/diag_psum_collector.md
DIAG_PSUM_COLLECTOR -- requirements
Module: diag_psum_collector

Interface
REQ-001 SHALL have parameter DW, default 16: width of each diagonal lane and of each output word.
REQ-002 SHALL have parameter Dimension, default 16: number of diagonal lanes.
REQ-003 SHALL have parameter ACC_W, default 24 (ACC_W > DW): signed accumulator width per lane.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port diag_valid, input, 1: diag_in carries a valid diagonal psum vector this cycle.
REQ-007 SHALL have port diag_in, input, DW*Dimension: signed diagonal PE outputs, lane k at bits [DW*(k+1)-1 : DW*k].
REQ-008 SHALL have port diag_last, input, 1: qualifies the final vector of a tile; sampled only with diag_valid.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-010 SHALL have port out_valid, output, 1: out_data/out_lane valid.
REQ-011 SHALL have port out_data, output, DW: signed reduced lane result.
REQ-012 SHALL have port out_lane, output, $clog2(Dimension): lane index of out_data.
REQ-013 SHALL have port out_last, output, 1: high on lane Dimension-1 beat.
REQ-014 SHALL have port busy, output, 1: high in DRAIN state.
REQ-015 SHALL have port ovf_err, output, 1: sticky accumulator-overflow flag.
REQ-016 SHALL have port drop_err, output, 1: sticky flag, diag_valid seen during DRAIN.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DRAIN.
REQ-018 In IDLE/ACCUM, diag_valid SHALL add sign-extended lane k to acc[k] at the next edge for all k simultaneously; IDLE->ACCUM on diag_valid without diag_last.
REQ-019 diag_valid with diag_last in IDLE/ACCUM SHALL accumulate that vector and enter DRAIN at the same edge, lane counter = 0.
REQ-020 In DRAIN, out_valid SHALL be 1, out_lane = counter, out_data = reduce(acc[counter]); first beat visible the cycle after the diag_last edge (latency 1).
REQ-021 A beat SHALL transfer only when out_valid && out_ready; counter increments per transfer; outputs SHALL hold stable while out_ready = 0.
REQ-022 On transfer of lane Dimension-1 (out_last = 1), all acc SHALL clear to 0 and FSM SHALL return to IDLE at that edge.
REQ-023 diag_valid during DRAIN SHALL be ignored (acc unchanged) and SHALL set drop_err.
REQ-024 Signed overflow of any ACC_W lane add SHALL wrap two's-complement and set ovf_err.
REQ-025 ovf_err and drop_err SHALL clear only on rst.
REQ-026 Outside DRAIN, out_valid, out_last SHALL be 0; out_data, out_lane SHALL be 0.

Reset
REQ-027 rst SHALL immediately force IDLE, counter 0, all acc 0, all outputs 0, both error flags 0, including mid-DRAIN; the interrupted tile SHALL be discarded.

Configuration
REQ-028 Macro PSUM_SAT_EN: defined -> reduce() saturates acc to [-2^(DW-1), 2^(DW-1)-1]; undefined -> reduce() returns acc[DW-1:0] (truncation). No other behaviour differs.

Verification
REQ-029 Lanes all = 3, three vectors, third with diag_last, out_ready = 1 -> 16 beats, each out_data = 9, out_lane 0..15, out_last on lane 15, then IDLE.
REQ-030 Lane 5 = 0x7FFF over 2 vectors (acc 65534) -> lane 5 out_data = 0x7FFF with PSUM_SAT_EN, 0xFFFE without; ovf_err = 0.
REQ-031 out_ready toggled 1,0,0,1 during DRAIN -> out_data/out_lane hold during stalls, no beat lost or duplicated, 16 beats total.
REQ-032 diag_valid = 1 (lanes = 7) during DRAIN -> drop_err = 1, drained values unchanged, next tile starts from acc = 0.
REQ-033 rst pulsed after lane 4 transferred -> outputs 0 same cycle; new single vector lanes = -2 with diag_last -> 16 beats of 0xFFFE.
REQ-034 ACC_W = 17, lane 0 = 0x7FFF added 3 times -> ovf_err = 1, lane 0 acc wraps to 0x17FFD (two's complement 17-bit).
